// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-organised data-memory req/ack bus between the LSU (master) and memory (slave).
interface load_store_unit_if #(parameter int DATA_WIDTH = 32);
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage loads/stores over a req/ack word bus with lane steering and extension.
module load_store_unit #(parameter int DATA_WIDTH = 32) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  lsu_busy,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  rd_valid,
    output logic                  lsu_err,
    load_store_unit_if.master     mem
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t                state_q, state_d;
    logic                  we_q, we_d, rd_valid_q, rd_valid_d, err_q, err_d;
    logic [3:0]            be_q, be_d;
    logic [1:0]            lane_q, lane_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  accept, illegal, misaligned, fault, start, done;
    logic [3:0]            be_acc;
    logic [DATA_WIDTH-1:0] wdata_acc, lane_word, load_ext;
    always_comb begin
        accept     = state_q == IDLE && ex_valid && (MemRead || MemWrite);
        illegal    = MemWrite ? (Funct3[2] || Funct3[1:0] == 2'b11) : (Funct3[1:0] == 2'b11 || Funct3[2:1] == 2'b11);
        misaligned = (Funct3[1:0] == 2'b01 && ALUResult[0]) || (Funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00);
        fault      = illegal || misaligned;
        start      = accept && !fault;
        done       = state_q == WAIT && mem.mem_ack;
        be_acc     = Funct3[1:0] == 2'b00 ? 4'b0001 << ALUResult[1:0] :
                     Funct3[1:0] == 2'b01 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_acc  = Funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}} :
                     Funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
        // Unsigned variants have Funct3[2] set, which suppresses the sign fill
        lane_word  = mem.mem_rdata >> {lane_q, 3'b000};
        load_ext   = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane_word[7]}}, lane_word[7:0]} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane_word[15]}}, lane_word[15:0]} : lane_word;
        state_d    = done ? IDLE : start ? WAIT : state_q;
        we_d       = start ? MemWrite : we_q;
        addr_d     = start ? {ALUResult[DATA_WIDTH-1:2], 2'b00} : addr_q;
        be_d       = start ? be_acc : be_q;
        wdata_d    = start ? wdata_acc : wdata_q;
        lane_d     = start ? ALUResult[1:0] : lane_q;
        f3_d       = start ? Funct3 : f3_q;
        rd_valid_d = done && !we_q;
        rdata_d    = rd_valid_d ? load_ext : rdata_q;
        err_d      = accept && fault;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            f3_q       <= f3_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end
    assign lsu_busy      = reset && (start || (state_q == WAIT && !mem.mem_ack));
    assign ReadData      = rdata_q;
    assign rd_valid      = rd_valid_q;
    assign lsu_err       = err_q;
    assign mem.mem_req   = state_q == WAIT;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed loads/stores against a bench memory, checked each cycle by a behavioural model.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1, ex_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = 32'h0, WriteData = 32'h0;
    logic        lsu_busy, rd_valid, lsu_err;
    logic [31:0] ReadData;
    int          checks = 0, errors = 0;

    load_store_unit_if #(.DATA_WIDTH(32)) bus();
    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .lsu_busy(lsu_busy),
        .ReadData(ReadData), .rd_valid(rd_valid), .lsu_err(lsu_err), .mem(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Specification-level model of a single access
    function automatic bit err_f(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int n = 1 << f3[1:0];
        bit ill = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        return ill || (int'(a[1:0]) % n != 0);
    endfunction
    function automatic logic [3:0] be_f(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] t = 4'((1 << (1 << f3[1:0])) - 1);
        return t << a[1:0];
    endfunction
    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] wd);
        int n = 1 << f3[1:0];
        return n == 1 ? 32'(wd[7:0]) * 32'h0101_0101 : n == 2 ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    endfunction
    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        int n = 1 << f3[1:0];
        logic [31:0] mask, v;
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        v = (word >> (8 * int'(a[1:0]))) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Memory responder: acks after ack_delay extra cycles of mem_req
    logic [31:0] mem_arr [0:255];
    int ack_delay = 0, wait_cnt = 0;
    bit force_ack = 1'b0;
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[32'h100 >> 2] = 32'h80FF_1234;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack = force_ack;
            if (!bus.mem_req) wait_cnt = 0;
            else if (wait_cnt < ack_delay) wait_cnt++;
            else begin
                bus.mem_ack = 1'b1;
                wait_cnt = 0;
                if (bus.mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_be[i]) mem_arr[bus.mem_addr[9:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                end else begin
                    bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];
                end
            end
        end
    end

    // Per-cycle compare against the model
    bit m_wait = 1'b0, exp_rdv = 1'b0, exp_err = 1'b0, c_we = 1'b0;
    logic [31:0] m_rd = 32'h0, c_a = 32'h0, c_wd = 32'h0;
    logic [2:0] c_f3 = 3'b000;
    always @(negedge clk) begin
        bit acc, aerr, ack;
        if (!reset) begin
            chk("rst_flags", 32'({bus.mem_req, bus.mem_we, bus.mem_be, rd_valid, lsu_err, lsu_busy}), 32'h0);
            chk("rst_addr", bus.mem_addr, 32'h0);
            chk("rst_wdata", bus.mem_wdata, 32'h0);
            chk("rst_ReadData", ReadData, 32'h0);
            m_wait = 0; exp_rdv = 0; exp_err = 0; m_rd = 32'h0;
        end else begin
            acc  = !m_wait && ex_valid && (MemRead || MemWrite);
            aerr = err_f(MemWrite, Funct3, ALUResult);
            chk("lsu_busy", 32'(lsu_busy), 32'((acc && !aerr) || (m_wait && !bus.mem_ack)));
            chk("mem_req", 32'(bus.mem_req), 32'(m_wait));
            chk("lsu_err", 32'(lsu_err), 32'(exp_err));
            chk("rd_valid", 32'(rd_valid), 32'(exp_rdv));
            chk("ReadData", ReadData, m_rd);
            if (m_wait) begin
                chk("mem_we", 32'(bus.mem_we), 32'(c_we));
                chk("mem_addr", bus.mem_addr, {c_a[31:2], 2'b00});
                chk("mem_be", 32'(bus.mem_be), 32'(be_f(c_f3, c_a)));
                if (c_we) chk("mem_wdata", bus.mem_wdata, wdata_f(c_f3, c_wd));
            end
            ack = m_wait && bus.mem_ack;
            exp_rdv = ack && !c_we;
            if (exp_rdv) m_rd = load_f(c_f3, c_a, mem_arr[c_a[9:2]]);
            exp_err = acc && aerr;
            if (ack) m_wait = 0;
            if (acc && !aerr) begin
                m_wait = 1; c_we = MemWrite; c_a = ALUResult; c_f3 = Funct3; c_wd = WriteData;
            end
        end
    end

    // Trace of one access, index 0 = accept cycle
    logic        tr_busy [64], tr_req [64], tr_rdv [64], tr_err [64], tr_ack [64], tr_we [64];
    logic [3:0]  tr_be [64];
    logic [31:0] tr_addr [64], tr_wdata [64], tr_rd [64];
    int          tr_n = 0;
    task automatic sample(input int k);
        tr_busy[k] = lsu_busy; tr_req[k] = bus.mem_req; tr_rdv[k] = rd_valid; tr_err[k] = lsu_err;
        tr_ack[k] = bus.mem_ack; tr_we[k] = bus.mem_we; tr_be[k] = bus.mem_be;
        tr_addr[k] = bus.mem_addr; tr_wdata[k] = bus.mem_wdata; tr_rd[k] = ReadData;
    endtask
    function automatic int cnt_req();
        int c = 0;
        for (int i = 0; i < tr_n; i++) c += int'(tr_req[i]);
        return c;
    endfunction
    function automatic int cnt_rdv();
        int c = 0;
        for (int i = 0; i < tr_n; i++) c += int'(tr_rdv[i]);
        return c;
    endfunction

    // Called at posedge+1; returns at posedge+1
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input int tail);
        bit b;
        int n = 0;
        ack_delay = dly;
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd; ex_valid = 1'b1;
        do begin
            @(negedge clk);
            sample(n);
            b = lsu_busy;
            n++;
            @(posedge clk);
            #1;
        end while (b && n < 40);
        checks++;
        if (b) begin
            errors++;
            $display("FAIL issue_timeout: lsu_busy still 1 after %0d cycles, expected 0", n);
        end
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        repeat (tail) begin
            @(negedge clk);
            sample(n);
            n++;
        end
        if (tail > 0) begin
            @(posedge clk);
            #1;
        end
        tr_n = n;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", 32'(lsu_busy), 32'h0);
        chk("init_req", 32'(bus.mem_req), 32'h0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 2);
        chk("lb_addr", tr_addr[1], 32'h100);
        chk("lb_be", 32'(tr_be[1]), 32'h8);
        chk("lb_rdv_T1", 32'(tr_rdv[1]), 32'h0);
        chk("lb_rdv_T2", 32'(tr_rdv[2]), 32'h1);
        chk("lb_data", tr_rd[2], 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 2);
        chk("lbu_data", tr_rd[2], 32'h0000_0080);
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 2);
        chk("lh_data", tr_rd[3], 32'hFFFF_80FF);
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 2, 2);
        chk("sh_we", 32'(tr_we[1]), 32'h1);
        chk("sh_be", 32'(tr_be[1]), 32'hC);
        chk("sh_wdata", tr_wdata[1], 32'hBEEF_BEEF);
        chk("sh_addr", tr_addr[1], 32'h200);
        chk("sh_req_cycles", 32'(cnt_req()), 32'd3);
        chk("sh_ack_busy", 32'({tr_ack[3], tr_busy[3]}), 32'h2);
        chk("sh_no_rdv", 32'(cnt_rdv()), 32'h0);
        issue(1'b1, 1'b0, 3'b101, 32'h301, 32'h0, 0, 2);
        chk("lhu_mis_busy_T0", 32'(tr_busy[0]), 32'h0);
        chk("lhu_mis_err", 32'({tr_err[1], tr_err[2]}), 32'h2);
        chk("lhu_mis_no_req", 32'(cnt_req()), 32'h0);
        issue(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 0, 2);
        chk("f3_011_busy_T0", 32'(tr_busy[0]), 32'h0);
        chk("f3_011_err", 32'({tr_err[1], tr_err[2]}), 32'h2);
        chk("f3_011_no_req", 32'(cnt_req()), 32'h0);
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678, 0, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 2);
        chk("b2b_gap_req", 32'(tr_req[0]), 32'h0);
        chk("b2b_busy_T0", 32'(tr_busy[0]), 32'h1);
        chk("b2b_lw_data", tr_rd[2], 32'h1234_5678);
        issue(1'b1, 1'b1, 3'b010, 32'h20, 32'hA5A5_0F0F, 0, 2);
        chk("both_we", 32'(tr_we[1]), 32'h1);
        chk("both_be", 32'(tr_be[1]), 32'hF);
        chk("both_no_rdv", 32'(cnt_rdv()), 32'h0);
        issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_0077, 1, 2);
        chk("sb_wdata", tr_wdata[1], 32'h7777_7777);
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 2);
        chk("sb_merge_data", tr_rd[2], 32'hBEEF_7700);
        ack_delay = 1000;
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h40; ex_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_rst_req", 32'(bus.mem_req), 32'h1);
        reset = 1'b0; ex_valid = 1'b0; MemRead = 1'b0;
        #1;
        chk("midrst_flags", 32'({bus.mem_req, bus.mem_we, bus.mem_be, rd_valid, lsu_err, lsu_busy}), 32'h0);
        chk("midrst_ReadData", ReadData, 32'h0);
        chk("midrst_addr", bus.mem_addr, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        chk("ghost_ack_req", 32'(bus.mem_req), 32'h0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        @(negedge clk);
        chk("ghost_ack_rdv", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 2);
        chk("post_rst_lw", tr_rd[2], 32'h1234_5678);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit that consumes the ALU result as an effective byte address and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) against a word-organised data memory through a req/ack handshake. It generates byte enables and lane-replicated store data, and sign- or zero-extends load data. It stalls the pipeline while a transaction is outstanding and flags misaligned or illegal-size accesses. It sits directly downstream of the ALU, between EX and the data memory, and feeds the write-back mux.

## Interface
- DATA_WIDTH, 32, data and address width; fixed at 32 for RV32 lane logic
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX-stage instruction valid
- MemRead  in  1  instruction is a load
- MemWrite  in  1  instruction is a store; wins if both MemRead and MemWrite are high
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
- ALUResult  in  32  effective byte address
- WriteData  in  32  store data (rs2)
- lsu_busy  out  1  stall request to pipeline
- ReadData  out  32  extended load result, registered
- rd_valid  out  1  one-cycle pulse: ReadData holds a new load result
- lsu_err  out  1  one-cycle pulse: misaligned or illegal Funct3; no memory access made
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address ({ALUResult[31:2], 2'b00})
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1 on a read

## Operation
- FSM states: IDLE, WAIT.
- Accept: in IDLE when ex_valid & (MemRead | MemWrite). Inputs are sampled at the accepting edge.
- Error check at accept:
  - Illegal Funct3 (011, 110, 111; or 100/101 on a store) -> lsu_err.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> lsu_err.
  - An erroring access stays in IDLE and never raises mem_req.
- Legal accept -> WAIT. mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata registered and held stable until ack.
- Stores:
  - SB: be = 1<<addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
  - SW: be = 1111; wdata = WriteData.
- Loads:
  - mem_be reflects the access size (same rule as stores).
  - On ack, select the lane by addr[1:0] from mem_rdata. B/H sign-extend; BU/HU zero-extend; W passes through.
- WAIT & mem_ack -> IDLE. On the ack edge, mem_req drops to 0. For loads, ReadData is loaded and rd_valid=1 for the following cycle. Stores produce no rd_valid.
- mem_ack in IDLE is ignored.
- ReadData holds its last value until the next load completes.
- Reset, async, any state (including mid-WAIT):
  - State goes to IDLE; the in-flight request is abandoned (mem_req drops immediately).
  - All outputs go to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData, rd_valid, lsu_err, lsu_busy.

## Timing
- T0 = accept cycle. lsu_busy is combinational: 1 in T0 for a legal access, 1 in WAIT while mem_ack=0, 0 in the ack cycle.
- Pipeline holds EX inputs stable while lsu_busy=1.
- Erroring access: lsu_busy=0 in T0; lsu_err=1 in T1 only.
- mem_req first high in T1. Memory may ack in T1 (earliest). If ack arrives in cycle Tk, rd_valid=1 in Tk+1. Minimum load latency is 2 cycles, accept to rd_valid.
- Back-to-back: a new access may be accepted in the cycle after the ack (IDLE). Its mem_req rises one cycle later, so mem_req has at least one low cycle between transactions.
- lsu_busy is forced to 0 while reset is low.

## Test plan
- Reset mid-WAIT: LW issued, no ack, reset low 1 cycle -> mem_req=0 immediately, all outputs 0, IDLE after release; a later ack is ignored.
- LB sign-extend: addr 0x103, mem_rdata 0x80FF_1234 with ack in T1 -> mem_addr 0x100, mem_be 1000, ReadData 0xFFFF_FF80, rd_valid in T2. Repeat as LBU -> 0x0000_0080.
- SH to 0x202, WriteData 0xDEAD_BEEF, ack delayed 3 cycles -> mem_we=1, mem_be 1100, mem_wdata 0xBEEF_BEEF, mem_addr 0x200; mem_req held 3 cycles; lsu_busy low in ack cycle; no rd_valid.
- LHU at 0x301 -> lsu_err pulse in T1, mem_req never asserts, lsu_busy=0 in T0. Funct3=011 load at 0x300 -> same response.
- Back-to-back SW 0x10 = 0x1234_5678 then LW 0x10 (memory model) -> ReadData 0x1234_5678; mem_req low for at least one cycle between the two requests.
- MemRead and MemWrite both high with Funct3=010, addr 0x20 -> treated as a store (mem_we=1, be 1111), no rd_valid.
